// File: rtl/axis_image_pkg.sv
// Shared types, LFSR constants and the pixel formula for the AXI-Stream image source.
// The pixel formula is also available to checkers that want the same numbering.
`timescale 1ns/1ps
package axis_image_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Galois form, right shift: taps 16,14,13,11 map to bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] pixel_fn(input logic [15:0] x,
                                             input logic [15:0] y,
                                             input logic [15:0] frame_idx,
                                             input logic [31:0] width);
        return ({16'd0, y} * width) + {16'd0, x} + {16'd0, frame_idx};
    endfunction

endpackage

// File: rtl/axis_image_lfsr.sv
// 16-bit Galois LFSR with enable; paces valid insertion when throttling is built in.
`timescale 1ns/1ps
module axis_image_lfsr
    import axis_image_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lfsr_o <= LFSR_SEED;
        end else if (en_i) begin
            lfsr_o <= {1'b0, lfsr_o[15:1]} ^ (lfsr_o[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/axis_image_source.sv
// AXI-Stream raster frame generator: sends a programmed number of frames per start.
// Build with AXIS_IMAGE_SOURCE_THROTTLE_EN to insert pseudo-random valid bubbles.
`timescale 1ns/1ps
`ifndef INPUT_BITS
`define INPUT_BITS 8
`endif

//  state  | meaning
//  IDLE   | waiting for start_i
//  STREAM | presenting pixels of the current frame
//  GAP    | valid low for GAP_CYCLES cycles between frames
//  DONE   | end of run; done_o pulses, then back to IDLE
module axis_image_source
    import axis_image_pkg::*;
#(
    parameter int OUTPUT_BITS = `INPUT_BITS,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 8,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   start_i,
    input  logic [15:0]            num_frames_i,
    output logic [OUTPUT_BITS-1:0] axis_s_data_o,
    output logic                   axis_s_valid_o,
    input  logic                   axis_s_ready_i,
    output logic                   axis_s_last_o,
    output logic                   axis_s_user_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam logic [15:0] X_LAST   = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] Y_LAST   = 16'(IMG_HEIGHT - 1);
    localparam logic [31:0] WIDTH32  = 32'(IMG_WIDTH);
    localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);

    state_t state_q, state_d;

    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] fidx_q, fidx_d;
    logic [15:0] frames_q, frames_d;
    logic [31:0] gap_q, gap_d;

    logic [OUTPUT_BITS-1:0] data_d;
    logic valid_d, last_d, user_d, busy_d, done_d;

    logic xfer, eol, eof, more_frames, stream_next, beat_ok;

`ifdef AXIS_IMAGE_SOURCE_THROTTLE_EN
    logic [15:0] lfsr;

    axis_image_lfsr u_lfsr (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (1'b1),
        .lfsr_o (lfsr)
    );

    assign beat_ok = (lfsr & 16'h0003) != 16'h0000;
`else
    assign beat_ok = 1'b1;
`endif

    assign xfer        = axis_s_valid_o && axis_s_ready_i;
    assign eol         = (x_q == X_LAST);
    assign eof         = eol && (y_q == Y_LAST);
    assign more_frames = (frames_q > 16'd1);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= IDLE;
            x_q            <= '0;
            y_q            <= '0;
            fidx_q         <= '0;
            frames_q       <= '0;
            gap_q          <= '0;
            axis_s_data_o  <= '0;
            axis_s_valid_o <= 1'b0;
            axis_s_last_o  <= 1'b0;
            axis_s_user_o  <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            y_q            <= y_d;
            fidx_q         <= fidx_d;
            frames_q       <= frames_d;
            gap_q          <= gap_d;
            axis_s_data_o  <= data_d;
            axis_s_valid_o <= valid_d;
            axis_s_last_o  <= last_d;
            axis_s_user_o  <= user_d;
            busy_o         <= busy_d;
            done_o         <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (num_frames_i != 16'd0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                if (xfer && eof) begin
                    if (!more_frames) begin
                        state_d = DONE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = STREAM;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == 32'd0) begin
                    state_d = STREAM;
                end
            end
            DONE: begin
                // stay until the done pulse has actually been presented
                if (done_o) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        fidx_d   = fidx_q;
        frames_d = frames_q;
        gap_d    = gap_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    x_d      = '0;
                    y_d      = '0;
                    fidx_d   = '0;
                    frames_d = num_frames_i;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (eol) begin
                        x_d = '0;
                        if (eof) begin
                            y_d      = '0;
                            fidx_d   = fidx_q + 16'd1;
                            frames_d = frames_q - 16'd1;
                            gap_d    = GAP_LOAD;
                        end else begin
                            y_d = y_q + 16'd1;
                        end
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                end
            end
            GAP: begin
                if (gap_q != 32'd0) begin
                    gap_d = gap_q - 32'd1;
                end
            end
            DONE: begin
                x_d      = '0;
                y_d      = '0;
                fidx_d   = '0;
                frames_d = '0;
                gap_d    = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        stream_next = (state_d == STREAM);
        valid_d     = 1'b0;
        if (stream_next) begin
            // a presented beat is held until accepted, whatever the throttle says
            valid_d = (axis_s_valid_o && !axis_s_ready_i) ? 1'b1 : beat_ok;
        end
        data_d = stream_next ? OUTPUT_BITS'(pixel_fn(x_d, y_d, fidx_d, WIDTH32)) : '0;
        last_d = stream_next && (x_d == X_LAST);
        user_d = stream_next && (x_d == 16'd0) && (y_d == 16'd0);
        busy_d = (state_d == STREAM) || (state_d == GAP) ||
                 ((state_q == IDLE) && (state_d == DONE));
        done_d = (state_d == DONE) && (state_q != IDLE) && !done_o;
    end

endmodule

// File: tb/tb_axis_image_source.sv
// Scoreboard bench for axis_image_source: a frame model fills an expected-beat queue,
// a monitor pops and compares on every accepted beat.
`timescale 1ns/1ps
module tb_axis_image_source;

    localparam int W   = 16;
    localparam int H   = 8;
    localparam int GAP = 4;
    localparam int OB  = 8;
`ifdef AXIS_IMAGE_SOURCE_THROTTLE_EN
    localparam bit THROTTLE = 1'b1;
`else
    localparam bit THROTTLE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [15:0] num = 16'd0;

    logic [OB-1:0] data;
    logic          valid, last, user, busy, done;
    logic [3:0]    data4;
    logic          valid4, last4, user4, busy4, done4;

    always #5 clk = ~clk;

    axis_image_source #(.OUTPUT_BITS(OB), .IMG_WIDTH(W), .IMG_HEIGHT(H), .GAP_CYCLES(GAP)) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .num_frames_i(num),
        .axis_s_data_o(data), .axis_s_valid_o(valid), .axis_s_ready_i(ready),
        .axis_s_last_o(last), .axis_s_user_o(user), .busy_o(busy), .done_o(done)
    );

    axis_image_source #(.OUTPUT_BITS(4), .IMG_WIDTH(W), .IMG_HEIGHT(H), .GAP_CYCLES(GAP)) dut4 (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .num_frames_i(num),
        .axis_s_data_o(data4), .axis_s_valid_o(valid4), .axis_s_ready_i(ready),
        .axis_s_last_o(last4), .axis_s_user_o(user4), .busy_o(busy4), .done_o(done4)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
        logic        fin;
        logic        gchk;
    } beat_t;

    beat_t exp_q[$];
    beat_t mb;
    int tests = 0, fails = 0, beats = 0, cyc = 0, last_xfer_cyc = 0, rmode = 0;
    logic hold_pend = 1'b0, done_pend = 1'b0;
    logic [OB-1:0] hd;
    logic hl, hu;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Every frame is a raster of W x H pixels numbered y*W + x + frame.
    task automatic push_run(input int n, input bit gchk_ok);
        for (int f = 0; f < n; f++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    beat_t b;
                    b.data = 32'(y * W + x + f);
                    b.last = (x == W - 1);
                    b.user = (x == 0 && y == 0);
                    b.fin  = (f == n - 1 && y == H - 1 && x == W - 1);
                    b.gchk = gchk_ok && f > 0 && x == 0 && y == 0;
                    exp_q.push_back(b);
                end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = ~ready;
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            hold_pend = 1'b0;
            done_pend = 1'b0;
        end else begin
            if (done_pend) begin
                check("done_pulse", 32'(done), 32'd1);
                done_pend = 1'b0;
            end
            if (hold_pend) begin
                check("hold_valid", 32'(valid), 32'd1);
                check("hold_beat", {22'd0, data, last, user}, {22'd0, hd, hl, hu});
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_beat: got data %0h, expected no beat (t=%0t)", data, $time);
                end else begin
                    mb = exp_q.pop_front();
                    check("data", 32'(data), 32'(mb.data[OB-1:0]));
                    check("last_user", {30'd0, last, user}, {30'd0, mb.last, mb.user});
                    check("data4", {25'd0, valid4, data4, last4, user4},
                          {25'd0, 1'b1, mb.data[3:0], mb.last, mb.user});
                    if (mb.gchk) check("gap_len", 32'(cyc - last_xfer_cyc), 32'(GAP + 1));
                    if (mb.fin) done_pend = 1'b1;
                    beats++;
                end
                last_xfer_cyc = cyc;
            end
            hold_pend = valid && !ready;
            hd = data;
            hl = last;
            hu = user;
        end
    end

    task automatic kick(input int n);
        @(posedge clk);
        #1;
        num   = 16'(n);
        start = 1'b1;
        push_run(n, (rmode == 0) && !THROTTLE);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
        if (n > 0 && !THROTTLE) check("first_valid", 32'(valid), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done after %0d cycles, expected done", budget);
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        check("busy_at_done", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, k, base;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_outs", {26'd0, data, busy, done}, 32'd0);
        check("rst_last_user", {30'd0, last, user}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        rmode = 0; kick(1); wait_done(600);
        rmode = 0; kick(3); wait_done(1200);
        rmode = 1; kick(1); wait_done(900);
        rmode = 2; kick(2); wait_done(1500);

        // a start while busy must not reload the frame count
        rmode = 0;
        kick(2);
        repeat (40) @(posedge clk);
        #1;
        num   = 16'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_mid_start", 32'(busy), 32'd1);
        wait_done(1000);

        // asynchronous reset mid-frame, then a clean restart
        rmode = 0;
        base  = beats;
        kick(1);
        k = 0;
        while ((beats - base) < 50 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("reached_beat50", 32'(beats - base), 32'd50);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_valid", 32'(valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        kick(1); wait_done(600);

        // zero frames: busy for one cycle, done on the next
        @(posedge clk);
        #1;
        num   = 16'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("zero_busy", {29'd0, busy, done, valid}, 32'b100);
        @(negedge clk);
        check("zero_done", {29'd0, busy, done, valid}, 32'b010);
        @(negedge clk);
        check("zero_after", {29'd0, busy, done, valid}, 32'b000);

        repeat (4) begin
            rmode = $urandom_range(0, 2);
            n     = $urandom_range(1, 3);
            kick(n);
            wait_done(n * 700 + 100);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_image_source.md
Name: axis_image_source

Overview:
- AXI-Stream image transmitter; generates deterministic raster frames for driving a DUT's slave input in the image VIP bench.
- Sits upstream of the DUT/fixture: its axis_s_* outputs connect to the DUT's axis_m_*_i inputs.
- Emits IMG_WIDTH x IMG_HEIGHT pixels per frame, with start-of-frame on user and end-of-line on last.
- Runs a programmed number of frames per start command.

Parameters:
OUTPUT_BITS, `INPUT_BITS, pixel data width (matches the DUT input width)
IMG_WIDTH, 16, pixels per line, >=1
IMG_HEIGHT, 8, lines per frame, >=1
GAP_CYCLES, 4, idle cycles between frames, >=0

Ports:
clk_i  input  1  clock
rstn_i  input  1  asynchronous active-low reset
start_i  input  1  single-cycle start command; ignored unless idle
num_frames_i  input  16  frames to send; sampled on an accepted start; 0 = none
axis_s_data_o  output  OUTPUT_BITS  pixel data
axis_s_valid_o  output  1  data valid
axis_s_ready_i  input  1  downstream ready
axis_s_last_o  output  1  last pixel of a line
axis_s_user_o  output  1  first pixel of a frame (SOF)
busy_o  output  1  high from an accepted start until done
done_o  output  1  one-cycle pulse after the last pixel of the last frame is accepted

Behaviour:
- Interface: one clock, clk_i. Reset rstn_i is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; all counters 0.
- All outputs are registered; no combinational path from any input to any output.
- Transfer occurs on a cycle with valid && ready.
- Once valid is high, data, last and user hold stable until the transfer occurs.
- Valid never drops without a transfer.
- State machine IDLE / STREAM / GAP / DONE:
  - IDLE: start_i=1 with num_frames_i!=0 -> STREAM. On that edge: latch frame count; clear x, y and frame index; busy_o=1. valid rises the cycle after start (latency 1).
  - IDLE: start_i=1 with num_frames_i=0 -> DONE directly. busy_o=1 for one cycle, then done_o pulses.
  - STREAM: on each transfer, advance x. At x=IMG_WIDTH-1, wrap x to 0 and increment y. At the last pixel of the frame (x=IMG_WIDTH-1, y=IMG_HEIGHT-1):
    - more frames remain -> GAP, or straight to STREAM when GAP_CYCLES=0;
    - otherwise -> DONE.
  - With no transfer, all state holds.
  - GAP: valid=0 for exactly GAP_CYCLES cycles, then STREAM with the next frame index.
  - DONE: done_o=1 and busy_o=0 for one cycle, then IDLE.
- Pixel data: (y*IMG_WIDTH + x + frame_idx) mod 2^OUTPUT_BITS.
  - frame_idx is 16 bits, incremented at each frame end.
  - Arithmetic is computed at 32 bits, then truncated to OUTPUT_BITS.
- last = (x == IMG_WIDTH-1). user = (x==0 && y==0).
- With IMG_WIDTH=1, every pixel has last=1.
- start_i while busy is ignored; the frame count is not reloaded.
- Continuous ready gives one pixel per cycle with no bubbles inside a frame, including across line boundaries.
- Reset mid-frame: valid drops immediately (asynchronous). No partial-frame resume; the next start begins at pixel 0, frame 0.

Optional Feature:
- Macro: AXIS_IMAGE_SOURCE_THROTTLE_EN.
- Defined:
  - A 16-bit Galois LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle.
  - In STREAM, when valid is low, the next valid is inserted only if LFSR[1:0] != 2'b00. This gives roughly 25% idle bubbles.
  - Once asserted, valid obeys the hold rule regardless of the LFSR.
- Undefined: no LFSR logic is present; behaviour is exactly as described above.

Decomposition:
- Package axis_image_pkg:
  - state enum typedef (IDLE, STREAM, GAP, DONE);
  - LFSR seed and taps constants;
  - pixel_fn function for expected-pixel computation, shared with the checker scoreboard.
- One sub-module, axis_image_lfsr: a 16-bit LFSR with enable, instantiated only under the macro.
- Counters and FSM stay in the top module.

Test Plan:
- Reset, then start with num_frames_i=1, ready tied 1, IMG 16x8 -> 128 consecutive valid beats.
  - data 0..127;
  - user only on beat 0;
  - last on beats 15,31,...,127;
  - done_o pulses the cycle after beat 127.
- num_frames_i=3, GAP_CYCLES=4, ready=1 -> three frames with exactly 4 invalid cycles between each.
  - frame 2 first pixel = 2;
  - frame 2 last pixel = 129.
- Ready toggled 1010 and random during a frame -> data/last/user stable while valid && !ready; sequence identical to the ready=1 case.
- OUTPUT_BITS=4 -> data wraps 15 -> 0 at beat 16 of frame 0.
- start_i pulsed mid-frame -> ignored; the frame count is unchanged.
- rstn_i asserted at beat 50 -> valid=0 immediately. A new start restarts at data 0 with user=1.
- num_frames_i=0 -> no valid beats; done_o pulses 2 cycles after start.
